// File: rtl/matrix_mac_engine.sv
// Sequential unsigned matrix multiplier: C = A*B, one MAC per cycle, results streamed row-major.
// Define MM_CHECKSUM_EN to add res_sum, the running total of accepted results in the current job.
module matrix_mac_engine #(
   parameter int DW      = 4,
   parameter int MAX_DIM = 2,
   parameter int SW      = $clog2(MAX_DIM + 1),
   parameter int ACC_W   = 2 * DW + $clog2(MAX_DIM)
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          start,
   input  logic [SW-1:0]                 R1,
   input  logic [SW-1:0]                 C1,
   input  logic [SW-1:0]                 R2,
   input  logic [SW-1:0]                 C2,
   input  logic [MAX_DIM*MAX_DIM*DW-1:0] mat_a,
   input  logic [MAX_DIM*MAX_DIM*DW-1:0] mat_b,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [ACC_W-1:0]              res_data,
   output logic [SW-1:0]                 res_row,
   output logic [SW-1:0]                 res_col,
   output logic                          res_last,
   output logic                          busy,
`ifdef MM_CHECKSUM_EN
   output logic [ACC_W-1:0]              res_sum,
`endif
   output logic                          dim_err
);

   localparam int N  = MAX_DIM * MAX_DIM;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [SW-1:0] MAX_SZ = SW'(MAX_DIM);
   localparam logic [SW-1:0] ONE    = SW'(1);

   typedef enum logic [1:0] {IDLE, CHECK, MAC, EMIT} state_t;
   state_t state_reg, state_next;

   logic [SW-1:0]     r1_reg, c1_reg, r2_reg, c2_reg;
   logic [SW-1:0]     i_reg, j_reg, k_reg;
   logic [N*DW-1:0]   a_reg, b_reg;
   logic [DW-1:0]     a_arr [N];
   logic [DW-1:0]     b_arr [N];
   logic [2*DW-1:0]   prod_reg;
   logic [ACC_W-1:0]  acc_reg;
   logic              dim_err_reg;
   logic [IW-1:0]     a_idx, b_idx;
   logic              size_err, is_last, accept, handshake;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign a_arr[gi] = a_reg[gi*DW +: DW];
         assign b_arr[gi] = b_reg[gi*DW +: DW];
      end
   endgenerate

   assign a_idx = IW'(i_reg) * IW'(MAX_DIM) + IW'(k_reg);
   assign b_idx = IW'(k_reg) * IW'(MAX_DIM) + IW'(j_reg);

   assign size_err = (c1_reg != r2_reg) ||
                     (r1_reg == '0) || (c1_reg == '0) || (r2_reg == '0) || (c2_reg == '0) ||
                     (r1_reg > MAX_SZ) || (c1_reg > MAX_SZ) || (r2_reg > MAX_SZ) || (c2_reg > MAX_SZ);
   assign is_last   = (i_reg == r1_reg - ONE) && (j_reg == c2_reg - ONE);
   // The dim_err cycle still counts as busy, so a start landing there is dropped.
   assign accept    = start && (state_reg == IDLE) && !dim_err_reg;
   assign handshake = (state_reg == EMIT) && res_ready;

   assign res_valid = (state_reg == EMIT);
   assign res_data  = res_valid ? acc_reg : '0;
   assign res_row   = res_valid ? i_reg : '0;
   assign res_col   = res_valid ? j_reg : '0;
   assign res_last  = res_valid && is_last;
   assign busy      = (state_reg != IDLE) || dim_err_reg;
   assign dim_err   = dim_err_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = CHECK;
         CHECK:   state_next = size_err ? IDLE : MAC;
         MAC:     if (k_reg == c1_reg) state_next = EMIT;
         EMIT:    if (res_ready) state_next = is_last ? IDLE : MAC;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // The product is registered ahead of the adder, so MAC runs one extra
   // cycle (k == C1) to fold in the final product.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r1_reg      <= '0;
         c1_reg      <= '0;
         r2_reg      <= '0;
         c2_reg      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         i_reg       <= '0;
         j_reg       <= '0;
         k_reg       <= '0;
         prod_reg    <= '0;
         acc_reg     <= '0;
         dim_err_reg <= 1'b0;
      end else begin
         dim_err_reg <= (state_reg == CHECK) && size_err;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  r1_reg <= R1;
                  c1_reg <= C1;
                  r2_reg <= R2;
                  c2_reg <= C2;
                  a_reg  <= mat_a;
                  b_reg  <= mat_b;
               end
            end
            CHECK: begin
               i_reg   <= '0;
               j_reg   <= '0;
               k_reg   <= '0;
               acc_reg <= '0;
            end
            MAC: begin
               if (k_reg != c1_reg) begin
                  prod_reg <= (2*DW)'(a_arr[a_idx]) * (2*DW)'(b_arr[b_idx]);
                  k_reg    <= k_reg + ONE;
               end
               if (k_reg != '0) acc_reg <= acc_reg + ACC_W'(prod_reg);
            end
            EMIT: begin
               if (res_ready && !is_last) begin
                  acc_reg <= '0;
                  k_reg   <= '0;
                  if (j_reg == c2_reg - ONE) begin
                     j_reg <= '0;
                     i_reg <= i_reg + ONE;
                  end else begin
                     j_reg <= j_reg + ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MM_CHECKSUM_EN
   logic [ACC_W-1:0] sum_reg;

   always_ff @(posedge CLK) begin
      if (RST)            sum_reg <= '0;
      else if (accept)    sum_reg <= '0;
      else if (handshake) sum_reg <= sum_reg + acc_reg;
   end

   assign res_sum = sum_reg;
`endif

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench for matrix_mac_engine: directed and random jobs against a matrix-product model.
module tb_matrix_mac_engine;
   localparam int DW = 4, MAXD = 2, SW = 2, AW = 9;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic [SW-1:0] R1 = '0, C1 = '0, R2 = '0, C2 = '0;
   logic [15:0]   mat_a = '0, mat_b = '0;
   logic          res_ready = 1'b0;
   logic          res_valid, res_last, busy, dim_err;
   logic [AW-1:0] res_data;
   logic [SW-1:0] res_row, res_col;
`ifdef MM_CHECKSUM_EN
   logic [AW-1:0] res_sum;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      int data;
      int row;
      int col;
      int last;
   } res_t;

   matrix_mac_engine dut (
      .CLK(CLK), .RST(RST), .start(start),
      .R1(R1), .C1(C1), .R2(R2), .C2(C2),
      .mat_a(mat_a), .mat_b(mat_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_row(res_row), .res_col(res_col), .res_last(res_last),
      .busy(busy),
`ifdef MM_CHECKSUM_EN
      .res_sum(res_sum),
`endif
      .dim_err(dim_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // C[i][j] = sum_k A[i][k]*B[k][j] on the flattened row-major layout.
   function automatic int ref_elem(input logic [15:0] a, input logic [15:0] b,
                                   input int i, input int j, input int c1);
      int s = 0;
      for (int k = 0; k < c1; k++)
         s += int'(a[(i*MAXD+k)*DW +: DW]) * int'(b[(k*MAXD+j)*DW +: DW]);
      return s;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, res_valid, 0);
      check({tag, "_data"}, res_data, 0);
      check({tag, "_row"}, res_row, 0);
      check({tag, "_col"}, res_col, 0);
      check({tag, "_last"}, res_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_dim_err"}, dim_err, 0);
`ifdef MM_CHECKSUM_EN
      check({tag, "_sum"}, res_sum, 0);
`endif
   endtask

   // Launch one job and consume it; bp = cycles res_ready stays low after each new result.
   task automatic run_job(input int r1, input int c1, input int r2, input int c2, input int bp,
                          input logic [15:0] a, input logic [15:0] b, input bit mid_start);
      res_t exp_q[$];
      int t1, tc1, tr2, tc2, n_exp, e, last_hs, done_e, n_res, n_err, busy_cnt, wait_cnt, sum;
      bit err, pending;
      t1 = r1 % 4; tc1 = c1 % 4; tr2 = r2 % 4; tc2 = c2 % 4;
      err = (tc1 != tr2) || t1 == 0 || tc1 == 0 || tr2 == 0 || tc2 == 0 ||
            t1 > MAXD || tc1 > MAXD || tr2 > MAXD || tc2 > MAXD;
      if (!err)
         for (int i = 0; i < t1; i++)
            for (int j = 0; j < tc2; j++)
               exp_q.push_back('{ref_elem(a, b, i, j, tc1), i, j, int'(i == t1-1 && j == tc2-1)});
      n_exp = exp_q.size();
      $display("job: R1=%0d C1=%0d R2=%0d C2=%0d bp=%0d expect_err=%0d results=%0d",
               t1, tc1, tr2, tc2, bp, err, n_exp);

      R1 = r1[SW-1:0]; C1 = c1[SW-1:0]; R2 = r2[SW-1:0]; C2 = c2[SW-1:0];
      mat_a = a; mat_b = b; start = 1'b1; res_ready = 1'b0;
      @(posedge CLK); #1;
      start = 1'b0;
      R1 = 2'($urandom); C1 = 2'($urandom); R2 = 2'($urandom); C2 = 2'($urandom);
      mat_a = 16'($urandom); mat_b = 16'($urandom);

      e = 0; last_hs = -1; done_e = -1; n_res = 0; n_err = 0; busy_cnt = 0;
      wait_cnt = 0; sum = 0; pending = 1'b0;
      while (1) begin
         if (busy) busy_cnt++;
         if (dim_err) n_err++;
         if (res_valid) begin
            if (!pending) begin
               pending = 1'b1;
               wait_cnt = bp;
               if (last_hs < 0) check("first_latency", e, tc1 + 2);
               else             check("elem_interval", e - last_hs, tc1 + 1);
            end
            if (exp_q.size() > 0) begin
               check("res_data", res_data, exp_q[0].data);
               check("res_row", res_row, exp_q[0].row);
               check("res_col", res_col, exp_q[0].col);
               check("res_last", res_last, exp_q[0].last);
            end else begin
               check("extra_result", res_valid, 0);
            end
            if (wait_cnt == 0) begin
               res_ready = 1'b1;
               n_res++;
               sum += int'(res_data);
               last_hs = e + 1;
               if (res_last) done_e = e + 1;
               pending = 1'b0;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
               res_ready = 1'b0;
               wait_cnt--;
            end
         end else begin
            if (pending) check("valid_dropped", res_valid, 1);
            res_ready = 1'b0;
         end
         start = mid_start && (e == 3);
         if (start) begin
            mat_a = 16'($urandom); mat_b = 16'($urandom);
         end
         if (e == done_e) begin
            check("busy_after_last", busy, 0);
            break;
         end
         if (err && e == 3) break;
         if (e >= 400) begin
            check("job_timeout", e, done_e);
            break;
         end
         @(posedge CLK); #1;
         e++;
      end
      start = 1'b0;
      res_ready = 1'b0;
      check("result_count", n_res, n_exp);
      check("dim_err_pulses", n_err, err ? 1 : 0);
      if (err) check("err_busy_cycles", busy_cnt, 2);
`ifdef MM_CHECKSUM_EN
      check("res_sum", res_sum, sum % 512);
`endif
   endtask

   initial begin
      int hs, v, rr1, rc1, rr2, rc2;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check_idle_outputs("reset");
      RST = 1'b0;
      @(posedge CLK); #1;

      run_job(2, 2, 2, 2, 0, 16'h4321, 16'h8765, 1'b0);
      run_job(1, 2, 2, 1, 0, 16'h0032, 16'h0504, 1'b0);
      run_job(2, 2, 2, 8, 0, 16'h1111, 16'h2222, 1'b0);
      run_job(2, 2, 1, 2, 0, 16'h1111, 16'h2222, 1'b0);
      run_job(2, 2, 2, 2, 3, 16'hFFFF, 16'hFFFF, 1'b1);

      // Reset while the (1,0) element is accumulating.
      R1 = 2; C1 = 2; R2 = 2; C2 = 2;
      mat_a = 16'($urandom); mat_b = 16'($urandom);
      start = 1'b1; res_ready = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      hs = 0;
      for (int c = 0; c < 50 && hs < 2; c++) begin
         if (res_valid) hs++;
         @(posedge CLK); #1;
      end
      check("pre_reset_busy", busy, 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      check_idle_outputs("mid_reset");
      RST = 1'b0;
      v = 0;
      for (int c = 0; c < 12; c++) begin
         v += int'(res_valid);
         @(posedge CLK); #1;
      end
      check("no_valid_after_reset", v, 0);
      res_ready = 1'b0;
      run_job(2, 2, 2, 2, 1, 16'($urandom), 16'($urandom), 1'b0);

      for (int n = 0; n < 8; n++) begin
         rr1 = int'($urandom_range(1, 2));
         rc1 = int'($urandom_range(1, 2));
         rc2 = int'($urandom_range(1, 2));
         rr2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : rc1;
         run_job(rr1, rc1, rr2, rc2, int'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom), n[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
